run_sequencer: RTL

Top-level run controller for the single-cycle 9-bit core. It accepts the external start/done handshake and latches a program select. Before each run it clears the 16-entry register file, parks the fetch unit at the selected program's base PC, and then enables execution. It stops the core on a HALT instruction or on a watchdog timeout, and reports done, timeout and the executed-instruction count.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/run_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the run sequencer: FSM states, halt encoding and
// per-program base addresses.
package seq_pkg;

    localparam int unsigned PC_W      = 11;
    localparam int unsigned INST_W    = 9;
    localparam int unsigned NUM_PROGS = 4;
    localparam int unsigned SEL_W     = 2;

    localparam logic [INST_W-1:0] HALT_INST = 9'h1FF;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

    localparam logic [NUM_PROGS-1:0][PC_W-1:0] PROG_BASE = {
        11'd768, 11'd512, 11'd256, 11'd0
    };

    function automatic logic [PC_W-1:0] prog_base(input logic [SEL_W-1:0] sel);
        return PROG_BASE[sel];
    endfunction

endpackage

// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: clears the register file, parks fetch at
// the selected program base, runs until HALT or watchdog, then reports.
module run_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 11,
    parameter int unsigned INST_WIDTH = 9,
    parameter int unsigned REG_WIDTH  = 4,
    parameter int unsigned CYC_WIDTH  = 16,
    parameter int unsigned MAX_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            prog_sel,
    input  logic [INST_WIDTH-1:0] inst,
    output logic                  fetch_reset,
    output logic [PC_WIDTH-1:0]   start_pc,
    output logic                  core_en,
    output logic                  rf_clr_en,
    output logic [REG_WIDTH-1:0]  rf_clr_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CYC_WIDTH-1:0]  cycle_count
);

    localparam logic [CYC_WIDTH-1:0] LAST_CYCLE = CYC_WIDTH'(MAX_CYCLES - 1);
    localparam logic [REG_WIDTH-1:0] LAST_REG   = {REG_WIDTH{1'b1}};

    seq_state_t            state_q, state_d;
    logic [1:0]            sel_q;
    logic [PC_WIDTH-1:0]   start_pc_q;
    logic [REG_WIDTH-1:0]  clr_idx_q;
    logic [CYC_WIDTH-1:0]  cycle_count_q;
    logic                  timeout_q;
    logic                  is_halt;
    logic                  accept;
    logic                  wd_hit;

    assign is_halt = (inst == INST_WIDTH'(HALT_INST));
    assign accept  = (state_q == IDLE) && start;
    assign wd_hit  = (cycle_count_q == LAST_CYCLE);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start)                  state_d = CLEAR;
            CLEAR: if (clr_idx_q == LAST_REG)  state_d = LOAD;
            LOAD:                              state_d = RUN;
            RUN:   if (is_halt || wd_hit)      state_d = DONE;
            DONE:  if (!start)                 state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // State-decoded outputs; core_en must follow inst within the cycle
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        rf_clr_en   = 1'b0;
        fetch_reset = 1'b1;
        core_en     = 1'b0;
        case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                rf_clr_en = 1'b1;
            end
            LOAD: begin
                busy = 1'b1;
            end
            RUN: begin
                busy        = 1'b1;
                fetch_reset = 1'b0;
                core_en     = !is_halt;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Program select and base PC are captured once per accepted start
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q      <= 2'd0;
            start_pc_q <= PC_WIDTH'(prog_base(2'd0));
        end else if (accept) begin
            sel_q      <= prog_sel;
            start_pc_q <= PC_WIDTH'(prog_base(prog_sel));
        end else if (state_q == CLEAR || state_q == LOAD) begin
            start_pc_q <= PC_WIDTH'(prog_base(sel_q));
        end
    end

    // Register-file clear index
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_idx_q <= '0;
        end else if (accept) begin
            clr_idx_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_idx_q <= clr_idx_q + REG_WIDTH'(1);
        end
    end

    // Executed-instruction counter and watchdog; halt is never counted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
        end else if (accept) begin
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
        end else if (state_q == RUN && !is_halt) begin
            cycle_count_q <= cycle_count_q + CYC_WIDTH'(1);
            if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign start_pc    = start_pc_q;
    assign rf_clr_idx  = clr_idx_q;
    assign cycle_count = cycle_count_q;
    assign timeout     = timeout_q;

endmodule
